// File: rtl/apb_sched_pkg.sv
// Shared types and helpers for the round-robin APB master.
//   apb_st_e : APB transfer phase (IDLE -> SETUP -> ACCESS)
//   DEF_*    : default widths/depths used by apb_master_sched
//   oh2idx   : one-hot (up to 8 bits) to binary index
package apb_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_st_e;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_TIMEOUT_CYC = 256;

  // OR-reduction of set-bit positions; exact for a one-hot input.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = idx | 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
// Ports:
//   req        in  NUM_REQ  pending requests
//   ptr        in  IW       highest-priority position this round
//   gnt_onehot out NUM_REQ  winner, one-hot (0 when no request)
//   gnt_idx    out IW       winner index
//   any_req    out 1        any request pending
module apb_rr_arb
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]      gnt_idx,
  output logic               any_req
);

  // Walk from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    gnt_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  assign gnt_idx = IW'(oh2idx(8'(gnt_onehot)));
  assign any_req = |req;

endmodule

// File: rtl/apb_master_sched.sv
// Round-robin APB master: NUM_REQ requesters share one APB bus. Each transfer
// runs IDLE -> SETUP -> ACCESS and the result is returned to its requester.
// Optional build macro: APB_MASTER_SCHED_TIMEOUT_EN adds an ACCESS-phase abort
// after TIMEOUT_CYC cycles without PREADY.
// Ports:
//   PCLK, PRESET              clock, synchronous active-high reset
//   req_valid/write/addr/wdata per-requester request (addr/wdata packed by index)
//   req_ready                 one-hot accept pulse
//   rsp_valid/rsp_rdata/rsp_err  one-hot completion pulse + data/error
//   err_timeout               pulse on timeout abort (0 without the macro)
//   PSEL..PSLVERR             APB master interface
module apb_master_sched
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          err_timeout,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IW = $clog2(NUM_REQ);

  apb_st_e              state, nxt;
  logic [IW-1:0]        ptr, gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh, win_oh;
  logic                 any_req, to_hit;
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  apb_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .gnt_onehot(gnt_oh),
    .gnt_idx   (gnt_idx),
    .any_req   (any_req)
  );

`ifdef APB_MASTER_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  logic [CW-1:0] acc_cnt;
  logic          err_to_q;

  // acc_cnt = ACCESS cycles already spent without PREADY.
  assign to_hit = (acc_cnt == CW'(TIMEOUT_CYC - 1)) && !PREADY;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      acc_cnt  <= '0;
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= (state == ST_ACCESS) && to_hit;
      if (state == ST_SETUP)
        acc_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY)
        acc_cnt <= acc_cnt + 1'b1;
    end
  end
  assign err_timeout = err_to_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
  // Depth is only meaningful when the abort logic is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (any_req) nxt = ST_SETUP;
      ST_SETUP:  nxt = ST_ACCESS;
      ST_ACCESS: if (PREADY || to_hit) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Bus and response registers; the request is captured at grant so PADDR,
  // PWDATA and PWRITE stay put through ACCESS whatever the requester does.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr       <= '0;
      win_oh    <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            req_ready <= gnt_oh;
            win_oh    <= gnt_oh;
            PADDR     <= addr_a[gnt_idx];
            PWDATA    <= wdata_a[gnt_idx];
            PWRITE    <= req_write[gnt_idx];
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            ptr       <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_SETUP: PENABLE <= 1'b1;
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= win_oh;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
          end else if (to_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= win_oh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_sched.sv
module tb_apb_master_sched;

  localparam int TO = 8;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [3:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  rsp_rdata, PADDR, PWDATA, PRDATA;
  logic         rsp_err, err_timeout, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  logic [31:0] ba [4];
  logic [31:0] bw [4];
  logic [3:0]  bwr;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_addr[g*32 +: 32]  = ba[g];
    assign req_wdata[g*32 +: 32] = bw[g];
  end
  assign req_write = bwr;

  always #5 PCLK = ~PCLK;

  apb_master_sched #(.NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_timeout(err_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct packed {
    logic [3:0]      mask;
    logic            wr;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0]      dly;
    logic [31:0]     prdata;
    logic            slverr;
    logic [2:0]      n;
    logic [3:0][1:0] ord;
  } row_t;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic row_t mk(input logic [3:0] mask, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int dly, input logic [31:0] prdata,
                              input logic slverr, input int n, input int o0, input int o1,
                              input int o2, input int o3);
    row_t r;
    r.mask = mask; r.wr = wr; r.addr = addr; r.wdata = wdata; r.dly = 4'(dly);
    r.prdata = prdata; r.slverr = slverr; r.n = 3'(n);
    r.ord[0] = 2'(o0); r.ord[1] = 2'(o1); r.ord[2] = 2'(o2); r.ord[3] = 2'(o3);
    return r;
  endfunction

  function automatic int pick(input logic [3:0] p, input int s);
    for (int k = 0; k < 4; k++)
      if (p[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    PRESET = 1'b1; req_valid = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    PRESET = 1'b0;
  endtask

  // One scenario: requesters in r.mask all pending, served in the order r.ord.
  task automatic xfer_row(input row_t r);
    logic [3:0] pend;
    int w, got;
    pend = r.mask;
    for (int i = 0; i < 4; i++) begin
      ba[i] = r.addr + 32'(i) * 32'h100;
      bw[i] = r.wdata ^ 32'(i);
    end
    bwr = {4{r.wr}};
    for (int k = 0; k < int'(r.n); k++) begin
      w = int'(r.ord[k]);
      req_valid = pend;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        tick();
        if (req_ready != 0) got = c + 1;
      end
      chk("grant_latency", 64'(got), 64'(1));
      chk("req_ready", 64'(req_ready), 64'(1 << w));
      chk("setup_ctrl", 64'({PSEL, PENABLE, PWRITE}), 64'({2'b10, r.wr}));
      chk("setup_paddr", 64'(PADDR), 64'(ba[w]));
      chk("setup_pwdata", 64'(PWDATA), 64'(bw[w]));
      pend[w] = 1'b0;
      req_valid = pend;
      tick();
      chk("access_entry", 64'({PSEL, PENABLE}), 64'(2'b11));
      for (int d = 0; d <= int'(r.dly); d++) begin
        PREADY = (d == int'(r.dly)); PRDATA = r.prdata; PSLVERR = r.slverr;
        tick();
        if (d < int'(r.dly)) begin
          chk("access_hold", 64'({PSEL, PENABLE, rsp_valid}), 64'({2'b11, 4'b0000}));
          chk("paddr_stable", 64'(PADDR), 64'(ba[w]));
        end
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      chk("rsp_valid", 64'(rsp_valid), 64'(1 << w));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(r.wr ? 32'h0 : r.prdata));
      chk("rsp_err", 64'(rsp_err), 64'(r.slverr));
      chk("idle_after", 64'({PSEL, PENABLE}), 64'(0));
    end
    req_valid = '0;
  endtask

  row_t rows [10];

  initial begin
    int ng, last, gi;
    int gidx [5];
    int mptr, w, cur, phase, nacc;
    bit busy, rdy, e_to;
    logic [3:0] pend, e_ready, e_rsp;
    logic [31:0] e_rd, c_addr, c_wd;
    logic e_err, c_wr;

    // Expected RR order assumes ptr=0 after reset and advances row to row.
    rows[0] = mk(4'b0001, 1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,    1'b0, 1, 0, 0, 0, 0); // ptr->1
    rows[1] = mk(4'b0100, 1'b0, 32'h200, 32'h0,        5, 32'h1234, 1'b1, 1, 2, 0, 0, 0); // ptr->3
    rows[2] = mk(4'b1000, 1'b1, 32'h30,  32'h11112222, 1, 32'hBAD,  1'b0, 1, 3, 0, 0, 0); // ptr->0
    rows[3] = mk(4'b0010, 1'b0, 32'h40,  32'h0,        0, 32'hA5A5, 1'b0, 1, 1, 0, 0, 0); // ptr->2
    rows[4] = mk(4'b1010, 1'b1, 32'h50,  32'hCAFE,     2, 32'hFFFF, 1'b0, 2, 3, 1, 0, 0); // ptr->2
    rows[5] = mk(4'b1111, 1'b0, 32'h60,  32'h0,        1, 32'h55,   1'b0, 4, 2, 3, 0, 1); // ptr->2
    rows[6] = mk(4'b0011, 1'b1, 32'h70,  32'h3C3C,     0, 32'h0,    1'b0, 2, 0, 1, 0, 0); // ptr->2
    rows[7] = mk(4'b1001, 1'b0, 32'h80,  32'h0,        3, 32'h77,   1'b1, 2, 3, 0, 0, 0); // ptr->1
    rows[8] = mk(4'b0001, 1'b0, 32'h90,  32'h0,        2, 32'h99,   1'b0, 1, 0, 0, 0, 0); // ptr->1
    rows[9] = mk(4'b0001, 1'b1, 32'hA0,  32'h5A5A,     0, 32'h0,    1'b0, 1, 0, 0, 0, 0); // ptr->1

    for (int i = 0; i < 4; i++) begin ba[i] = '0; bw[i] = '0; end
    bwr = '0; req_valid = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; PRESET = 1'b1;

    // Reset state
    tick(); tick();
    chk("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, err_timeout, PSEL, PENABLE, PWRITE}), 64'(0));
    chk("reset_bus", {PADDR, PWDATA}, 64'(0));
    chk("reset_rdata", 64'(rsp_rdata), 64'(0));
    PRESET = 1'b0;
    tick();
    chk("idle_quiet", 64'({req_ready, rsp_valid, PSEL}), 64'(0));

    for (int r = 0; r < 10; r++) xfer_row(rows[r]);

    // Reset mid-ACCESS: transfer dropped, no response, pointer back to 0.
    ba[2] = 32'h2C0; bwr = '0; req_valid = 4'b0100; PREADY = 1'b0;
    tick();
    chk("t1_grant", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    tick(); tick();
    chk("t1_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    PRESET = 1'b1; PREADY = 1'b1;
    tick();
    PRESET = 1'b0;
    chk("t1_abort", 64'({PSEL, PENABLE, rsp_valid}), 64'(0));
    tick();
    chk("t1_quiet", 64'({PSEL, PENABLE, rsp_valid}), 64'(0));
    PREADY = 1'b0;
    xfer_row(mk(4'b1010, 1'b0, 32'h900, 32'h0, 1, 32'h4242, 1'b0, 2, 1, 3, 0, 0));

    // All four held valid: 0,1,2,3,0 with one idle cycle between transfers.
    do_reset();
    req_valid = 4'b1111; PREADY = 1'b1;
    ng = 0; last = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      tick();
      if (req_ready != 0) begin
        gi = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
        gidx[ng] = gi;
        if (ng > 0) chk("rr_gap", 64'(c - last), 64'(3));
        last = c;
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 64'(5));
    for (int k = 0; k < ng; k++) chk("rr_order", 64'(gidx[k]), 64'(k % 4));
    do_reset();

    // Slave never ready.
    ba[0] = 32'h70; bwr = '0; req_valid = 4'b0001; PRDATA = 32'hFFFF0000;
    tick();
    chk("to_grant", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
`ifdef APB_MASTER_SCHED_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      tick();
      chk("to_wait", 64'({PSEL, PENABLE, err_timeout, rsp_valid}), 64'({3'b110, 4'b0000}));
    end
    tick();
    chk("to_abort", 64'({PSEL, err_timeout, rsp_err, rsp_valid}), 64'({3'b011, 4'b0001}));
    chk("to_rdata", 64'(rsp_rdata), 64'(0));
    tick();
    chk("to_pulse", 64'({err_timeout, rsp_valid}), 64'(0));
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("no_to_wait", 64'({PSEL, PENABLE, err_timeout, rsp_valid}), 64'({3'b110, 4'b0000}));
    end
    PREADY = 1'b1;
    tick();
    chk("no_to_done", 64'({PSEL, rsp_valid}), 64'(5'b00001));
    PREADY = 1'b0;
`endif

    // Random traffic against a transaction-level model.
    do_reset();
    pend = '0; mptr = 0; busy = 0; cur = 0; phase = 0; nacc = 0; w = 0;
    c_addr = '0; c_wd = '0; c_wr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; ba[i] = $urandom; bw[i] = $urandom; bwr[i] = 1'($urandom_range(1));
        end
      req_valid = pend;
      rdy = ($urandom_range(2) == 0);
      PREADY = rdy; PRDATA = $urandom; PSLVERR = 1'($urandom_range(1));
      e_ready = '0; e_rsp = '0; e_to = 0; e_rd = '0; e_err = 1'b0;
      if (!busy) begin
        if (pend != 0) begin w = pick(pend, mptr); e_ready[w] = 1'b1; end
      end else if (phase > 0) begin
        if (rdy) begin
          e_rsp[cur] = 1'b1; e_rd = c_wr ? 32'h0 : PRDATA; e_err = PSLVERR;
        end
`ifdef APB_MASTER_SCHED_TIMEOUT_EN
        else if (nacc == TO - 1) begin
          e_rsp[cur] = 1'b1; e_rd = '0; e_err = 1'b1; e_to = 1;
        end
`endif
      end
      tick();
      chk("rnd_req_ready", 64'(req_ready), 64'(e_ready));
      chk("rnd_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      chk("rnd_err_timeout", 64'(err_timeout), 64'(e_to));
      if (e_rsp != 0) begin
        chk("rnd_rdata", 64'(rsp_rdata), 64'(e_rd));
        chk("rnd_err", 64'(rsp_err), 64'(e_err));
      end
      if (e_ready != 0) begin
        busy = 1; cur = w; phase = 0; mptr = (w + 1) % 4;
        c_addr = ba[w]; c_wd = bw[w]; c_wr = bwr[w]; pend[w] = 1'b0;
      end else if (busy) begin
        if (e_rsp != 0) busy = 0;
        else begin
          if (phase > 0) nacc++; else nacc = 0;
          phase++;
        end
      end
      if (busy) begin
        chk("rnd_ctrl", 64'({PSEL, PENABLE, PWRITE}), 64'({1'b1, phase > 0, c_wr}));
        chk("rnd_bus", {PADDR, PWDATA}, {c_addr, c_wd});
      end else
        chk("rnd_idle", 64'(PSEL), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
